dcache: RTL

Direct-mapped, write-through, no-write-allocate data cache between the MIPS MEM stage and the word-addressed DRAM model. It serves load hits in the same cycle and stalls the pipeline on load misses and on every store. On a stall it runs a single-word transaction on the DRAM `cs`/`we`/`ack` interface. It also exposes free-running hit and miss counters for performance runs.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_array.sv | 50 +++++
 rtl/dcache.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and helpers for the direct-mapped data cache.
//   state_t : controller states (IDLE, RD, WR, RESP)
//   idx_w   : index width for a given line count
//   tag_w   : tag width for a given byte-address width and line count
//   line_t  : one cache line {valid, tag, data} in the default 32-bit, 64-line layout
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Byte offset is always two bits (word-addressed DRAM).
  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

  localparam int LINE_TAG_W  = tag_w(32, 64);
  localparam int LINE_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [LINE_TAG_W-1:0]  tag;
    logic [LINE_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage for the direct-mapped cache.
//   clk, rst_n          : clock, async active-low clear of the valid bits only
//   rd_idx -> rd_valid, rd_tag, rd_data : combinational read port
//   wr_en, wr_idx, wr_tag, wr_data      : synchronous write port; a write
//                                          always marks the line valid
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [idx_w(LINES)-1:0]  rd_idx,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_en,
  input  logic [idx_w(LINES)-1:0]  wr_idx,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [DATA_W-1:0]        wr_data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data are meaningless while the valid bit is clear, so they
  // carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
//   clk, reset (async, active-low)
//   cpu_addr/cpu_re/cpu_we/cpu_wdata -> cpu_rdata/cpu_stall : pipeline side
//   mem_addr/mem_cs/mem_we/mem_wdata <- mem_rdata/mem_ack    : DRAM side
//   cnt_hit/cnt_miss : free-running load hit/miss counters
//   dbg_state        : current controller state
// DRAM handshake: mem_cs (with mem_we/mem_addr/mem_wdata) rises registered
// on entry to RD/WR and holds steady until the cycle after mem_ack; mem_ack
// is a one-cycle completion pulse, honoured only in RD/WR and ignored
// everywhere else. Load hits complete in the request cycle with no stall.
module dcache
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       cnt_hit,
  output logic [31:0]       cnt_miss,
  output state_t            dbg_state
);

  localparam int IDX_W  = idx_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES);
  localparam int WORD_W = ADDR_W - 2;

  state_t state_q, state_d;

  logic [WORD_W-1:0] addr_q;      // latched word address of the request
  logic [DATA_W-1:0] wdata_q;     // latched store data
  logic [DATA_W-1:0] resp_q;      // load data returned by DRAM
  logic [31:0]       cnt_hit_q, cnt_miss_q;
  logic              mem_cs_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // In IDLE the live CPU request drives lookup; afterwards the latched one
  // does, so the CPU may change its inputs while stalled.
  logic [WORD_W-1:0] req_word;
  logic [DATA_W-1:0] req_wdata;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              hit_inc, miss_inc;
  logic              txn_d;

  logic unused_offset;
  assign unused_offset = ^cpu_addr[1:0];

  assign req_word  = (state_q == IDLE) ? cpu_addr[ADDR_W-1:2] : addr_q;
  assign req_wdata = (state_q == IDLE) ? cpu_wdata : wdata_q;
  assign req_idx   = req_word[IDX_W-1:0];
  assign req_tag   = req_word[WORD_W-1:IDX_W];
  assign hit       = rd_valid && (rd_tag == req_tag);

  dcache_array #(
    .LINES  (LINES),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (reset),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (wr_data)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a store wins over a simultaneous load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_we)               state_d = WR;
        else if (cpu_re && !hit)  state_d = RD;
      end
      RD:      if (mem_ack) state_d = RESP;
      WR:      if (mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / array-write / counter-enable logic
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    wr_en     = 1'b0;
    wr_data   = wdata_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          cpu_stall = 1'b1;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = rd_data;
            hit_inc   = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            miss_inc  = 1'b1;
          end
        end
      end
      RD: begin
        cpu_stall = 1'b1;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
        end
      end
      // No-write-allocate: only a resident line picks up the store data.
      WR: begin
        cpu_stall = 1'b1;
        wr_en     = mem_ack && hit;
      end
      RESP:    cpu_rdata = resp_q;
      default: ;
    endcase
  end

  // Memory-port registers follow the next state, so they rise on entry to
  // RD/WR and fall in the cycle after the ack.
  assign txn_d = (state_d == RD) || (state_d == WR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_hit_q   <= '0;
      cnt_miss_q  <= '0;
    end else begin
      if (state_q == IDLE) begin
        addr_q  <= cpu_addr[ADDR_W-1:2];
        wdata_q <= cpu_wdata;
      end
      if (state_q == RD && mem_ack) resp_q <= mem_rdata;
      mem_cs_q    <= txn_d;
      mem_we_q    <= (state_d == WR);
      mem_addr_q  <= txn_d ? {req_word, 2'b00} : '0;
      mem_wdata_q <= (state_d == WR) ? req_wdata : '0;
      if (hit_inc)  cnt_hit_q  <= cnt_hit_q + 32'd1;
      if (miss_inc) cnt_miss_q <= cnt_miss_q + 32'd1;
    end
  end

  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cnt_hit   = cnt_hit_q;
  assign cnt_miss  = cnt_miss_q;
  assign dbg_state = state_q;

endmodule
